// File: rtl/mem_access_stage_if.sv
// ---------------------------------------------------------------------------
// mem_access_stage_if : EX/MEM inputs, data-memory handshake and MEM/WB outputs
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_access_stage_if;
   logic        ex_valid;
   logic [31:0] ex_aluresult;
   logic [31:0] ex_storedata;
   logic        ex_memread;
   logic        ex_memwrite;
   logic [1:0]  ex_size;
   logic [1:0]  ex_wb;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic [31:0] wb_datafrommem;
   logic [31:0] wb_datafromimm;
   logic [1:0]  wb_ctl;
   logic        wb_nop;
   logic [31:0] wb_datamask;
   logic        misalign;
   logic        bus_err;

   modport master (
      input  ex_valid, ex_aluresult, ex_storedata, ex_memread, ex_memwrite,
             ex_size, ex_wb, dmem_rdata, dmem_ack,
      output stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
             wb_datafrommem, wb_datafromimm, wb_ctl, wb_nop, wb_datamask,
             misalign, bus_err
   );

   modport slave (
      output ex_valid, ex_aluresult, ex_storedata, ex_memread, ex_memwrite,
             ex_size, ex_wb, dmem_rdata, dmem_ack,
      input  stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
             wb_datafrommem, wb_datafromimm, wb_ctl, wb_nop, wb_datamask,
             misalign, bus_err
   );
endinterface

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage : MIPS MEM stage, req/ack data-memory access and MEM/WB regs
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  wire logic          clk,
   input  wire logic          reset,
   mem_access_stage_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_WAIT = 2'd1,
      S_WR_WAIT = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_tcnt;
   logic [1:0]  r_off;
   logic [1:0]  r_size;

   logic        w_is_mem;
   logic        w_aligned;
   logic        w_start;
   logic        w_wait;
   logic        w_timeout;
   logic [3:0]  w_st_be;
   logic [31:0] w_st_wdata;
   logic [31:0] w_ld_mask;
   logic [31:0] w_ld_data;

   assign w_is_mem  = bus.ex_valid & (bus.ex_memread | bus.ex_memwrite);
   assign w_aligned = (bus.ex_size == 2'b00)
                    | ((bus.ex_size == 2'b01) & ~bus.ex_aluresult[0])
                    | (bus.ex_size[1] & (bus.ex_aluresult[1:0] == 2'b00));
   assign w_start   = (r_state == S_IDLE) & w_is_mem & w_aligned;
   assign w_wait    = (r_state != S_IDLE);
   assign w_timeout = w_wait & ~bus.dmem_ack & (TIMEOUT_CYCLES != 0)
                    & (r_tcnt == TIMEOUT_CYCLES - 32'd1);
   // A timed-out op is dropped, so stall falls on the abort cycle as well
   assign bus.stall = ~reset & (w_start | (w_wait & ~bus.dmem_ack & ~w_timeout));

   always_comb begin
      w_st_be    = 4'b1111;
      w_st_wdata = bus.ex_storedata;
      case (bus.ex_size)
         2'b00: begin
            w_st_be    = 4'b0001 << bus.ex_aluresult[1:0];
            w_st_wdata = {4{bus.ex_storedata[7:0]}};
         end
         2'b01: begin
            w_st_be    = bus.ex_aluresult[1] ? 4'b1100 : 4'b0011;
            w_st_wdata = {2{bus.ex_storedata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (r_size)
         2'b00:   w_ld_mask = 32'h0000_00FF;
         2'b01:   w_ld_mask = 32'h0000_FFFF;
         default: w_ld_mask = 32'hFFFF_FFFF;
      endcase
   end

   assign w_ld_data = (bus.dmem_rdata >> {r_off, 3'b000}) & w_ld_mask;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state            <= S_IDLE;
         r_tcnt             <= 32'd0;
         r_off              <= 2'b00;
         r_size             <= 2'b00;
         bus.dmem_req       <= 1'b0;
         bus.dmem_we        <= 1'b0;
         bus.dmem_addr      <= 32'd0;
         bus.dmem_be        <= 4'b0000;
         bus.dmem_wdata     <= 32'd0;
         bus.wb_datafrommem <= 32'd0;
         bus.wb_datafromimm <= 32'd0;
         bus.wb_ctl         <= 2'b00;
         bus.wb_nop         <= 1'b1;
         bus.wb_datamask    <= 32'hFFFF_FFFF;
         bus.misalign       <= 1'b0;
         bus.bus_err        <= 1'b0;
      end else begin
         bus.misalign       <= 1'b0;
         bus.bus_err        <= 1'b0;
         bus.wb_datafromimm <= bus.ex_aluresult;
         bus.wb_datafrommem <= 32'd0;
         bus.wb_datamask    <= 32'hFFFF_FFFF;
         bus.wb_ctl         <= 2'b00;
         bus.wb_nop         <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state        <= bus.ex_memwrite ? S_WR_WAIT : S_RD_WAIT;
                  r_tcnt         <= 32'd0;
                  r_off          <= bus.ex_aluresult[1:0];
                  r_size         <= bus.ex_size;
                  bus.dmem_req   <= 1'b1;
                  bus.dmem_we    <= bus.ex_memwrite;
                  bus.dmem_addr  <= {bus.ex_aluresult[31:2], 2'b00};
                  bus.dmem_be    <= bus.ex_memwrite ? w_st_be : 4'b1111;
                  bus.dmem_wdata <= w_st_wdata;
               end else if (w_is_mem) begin
                  bus.misalign <= 1'b1;
               end else begin
                  bus.wb_ctl <= bus.ex_wb;
                  bus.wb_nop <= ~bus.ex_valid;
               end
            end
            default: begin
               if (bus.dmem_ack) begin
                  r_state      <= S_IDLE;
                  bus.dmem_req <= 1'b0;
                  bus.wb_ctl   <= bus.ex_wb;
                  bus.wb_nop   <= 1'b0;
                  if (r_state == S_RD_WAIT) begin
                     bus.wb_datafrommem <= w_ld_data;
                     bus.wb_datamask    <= w_ld_mask;
                  end
               end else if (w_timeout) begin
                  r_state      <= S_IDLE;
                  bus.dmem_req <= 1'b0;
                  bus.bus_err  <= 1'b1;
               end else begin
                  r_tcnt <= r_tcnt + 32'd1;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage : directed bench with a transaction-level MEM stage model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_stage;
   localparam int unsigned TO = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_access_stage_if bus();
   mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_pass  = 0;
   int n_total = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endfunction

   // ---------------- reference rules ----------------
   function automatic int nbytes(logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction
   function automatic bit is_aligned(logic [31:0] a, int nb);
      return (int'(a[1:0]) % nb) == 0;
   endfunction
   function automatic logic [31:0] size_mask(int nb);
      return (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
   endfunction
   function automatic logic [3:0] st_be(int nb, logic [1:0] off);
      logic [7:0] t;
      t = ((8'h1 << nb) - 8'h1) << off;
      return t[3:0];
   endfunction
   function automatic logic [31:0] st_wdata(int nb, logic [31:0] sd);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % nb) +: 8];
      return r;
   endfunction

   // ---------------- model: one outstanding transaction ----------------
   bit          m_pend = 0, m_wr = 0;
   logic [1:0]  m_off = 0;
   int          m_bytes = 4, m_waited = 0;
   logic        e_req = 0, e_we = 0, e_nop = 1, e_mis = 0, e_berr = 0;
   logic [31:0] e_addr = 0, e_wdata = 0, e_fmem = 0, e_fimm = 0, e_mask = 32'hFFFF_FFFF;
   logic [3:0]  e_be = 0;
   logic [1:0]  e_ctl = 0;

   function automatic bit timeout_now();
      return (TO != 0) && (m_waited + 1 == int'(TO));
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pend = 0; e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
         e_fmem = 0; e_fimm = 0; e_ctl = 0; e_nop = 1; e_mask = 32'hFFFF_FFFF;
         e_mis = 0; e_berr = 0;
      end else begin
         e_mis = 0; e_berr = 0; e_fimm = bus.ex_aluresult; e_fmem = 0;
         e_mask = 32'hFFFF_FFFF; e_nop = 1; e_ctl = 0;
         if (!m_pend) begin
            if (bus.ex_valid && (bus.ex_memread || bus.ex_memwrite)) begin
               if (is_aligned(bus.ex_aluresult, nbytes(bus.ex_size))) begin
                  m_pend = 1; m_wr = bus.ex_memwrite; m_off = bus.ex_aluresult[1:0];
                  m_bytes = nbytes(bus.ex_size); m_waited = 0;
                  e_req = 1; e_we = bus.ex_memwrite;
                  e_addr = bus.ex_aluresult & 32'hFFFF_FFFC;
                  e_be = m_wr ? st_be(m_bytes, m_off) : 4'b1111;
                  e_wdata = st_wdata(m_bytes, bus.ex_storedata);
               end else begin
                  e_mis = 1;
               end
            end else begin
               e_ctl = bus.ex_wb; e_nop = !bus.ex_valid;
            end
         end else if (bus.dmem_ack) begin
            m_pend = 0; e_req = 0; e_nop = 0; e_ctl = bus.ex_wb;
            if (!m_wr) begin
               e_fmem = (bus.dmem_rdata >> (8 * m_off)) & size_mask(m_bytes);
               e_mask = size_mask(m_bytes);
            end
         end else if (timeout_now()) begin
            m_pend = 0; e_req = 0; e_berr = 1;
         end else begin
            m_waited++;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [31:0] last_addr = 0, last_wdata = 0;
   logic [3:0]  last_be = 0;
   logic        last_we = 0;

   always @(negedge clk) begin
      logic exp_stall;
      if (reset) exp_stall = 0;
      else if (!m_pend)
         exp_stall = bus.ex_valid && (bus.ex_memread || bus.ex_memwrite)
                     && is_aligned(bus.ex_aluresult, nbytes(bus.ex_size));
      else exp_stall = !(bus.dmem_ack || timeout_now());
      chk("stall", bus.stall, exp_stall);
      chk("dmem_req", bus.dmem_req, e_req);
      chk("misalign", bus.misalign, e_mis);
      chk("bus_err", bus.bus_err, e_berr);
      chk("wb_nop", bus.wb_nop, e_nop);
      chk("wb_datamask", bus.wb_datamask, e_mask);
      if (e_req || reset) begin
         chk("dmem_addr", bus.dmem_addr, e_addr);
         chk("dmem_be", bus.dmem_be, e_be);
         chk("dmem_we", bus.dmem_we, e_we);
      end
      if ((e_req && e_we) || reset) chk("dmem_wdata", bus.dmem_wdata, e_wdata);
      if (!e_nop) begin
         chk("wb_ctl", bus.wb_ctl, e_ctl);
         chk("wb_datafrommem", bus.wb_datafrommem, e_fmem);
         chk("wb_datafromimm", bus.wb_datafromimm, e_fimm);
      end
      if (bus.dmem_req) begin
         last_addr = bus.dmem_addr; last_be = bus.dmem_be;
         last_we = bus.dmem_we; last_wdata = bus.dmem_wdata;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] sd,
                        input logic rd, input logic wr, input logic [1:0] sz,
                        input logic [1:0] wb);
      bus.ex_valid = v; bus.ex_aluresult = a; bus.ex_storedata = sd;
      bus.ex_memread = rd; bus.ex_memwrite = wr; bus.ex_size = sz; bus.ex_wb = wb;
   endtask

   task automatic idle();
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 2'b00);
   endtask

   task automatic alu_op(input logic [31:0] a, input logic [1:0] wb);
      @(posedge clk); #1;
      drive(1'b1, a, 32'd0, 1'b0, 1'b0, 2'b10, wb);
      @(posedge clk); #1;
      idle();
      chk("alu_fimm", bus.wb_datafromimm, a);
      chk("alu_nop", bus.wb_nop, 1'b0);
      chk("alu_ctl", bus.wb_ctl, wb);
   endtask

   // ack_after<0: never ack. Returns one cycle after the op leaves the stage.
   task automatic mem_op(input logic [31:0] a, input logic [31:0] sd, input logic rd,
                         input logic wr, input logic [1:0] sz, input logic [1:0] wb,
                         input int ack_after, input logic [31:0] rdat,
                         output int stall_cyc, output int req_cyc);
      bit fin = 0;
      @(posedge clk); #1;
      drive(1'b1, a, sd, rd, wr, sz, wb);
      stall_cyc = 0; req_cyc = 0;
      for (int k = 0; k < 30 && !fin; k++) begin
         if (bus.dmem_req) begin
            req_cyc++;
            if (ack_after >= 0 && req_cyc == ack_after + 1) begin
               bus.dmem_ack = 1'b1; bus.dmem_rdata = rdat;
            end
         end
         #1;
         if (bus.stall) stall_cyc++; else fin = 1;
         @(posedge clk); #1;
         bus.dmem_ack = 1'b0;
      end
      if (!fin) chk("op_cycle_bound", 32'd0, 32'd1);
      idle();
   endtask

   int sc, rc;

   initial begin
      idle();
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb_nop", bus.wb_nop, 1'b1);
      chk("rst_mask", bus.wb_datamask, 32'hFFFF_FFFF);
      chk("rst_req", bus.dmem_req, 1'b0);
      #1 reset = 1'b0;

      alu_op(32'h0000_1234, 2'b11);

      mem_op(32'h100, 32'd0, 1, 0, 2'b10, 2'b10, 3, 32'hDEAD_BEEF, sc, rc);
      chk("wl_stall_cycles", sc, 4);
      chk("wl_data", bus.wb_datafrommem, 32'hDEAD_BEEF);
      chk("wl_mask", bus.wb_datamask, 32'hFFFF_FFFF);
      chk("wl_nop", bus.wb_nop, 1'b0);

      mem_op(32'h103, 32'd0, 1, 0, 2'b00, 2'b10, 1, 32'hAABB_CCDD, sc, rc);
      chk("bl_addr", last_addr, 32'h100);
      chk("bl_be", last_be, 4'b1111);
      chk("bl_data", bus.wb_datafrommem, 32'h0000_00AA);
      chk("bl_mask", bus.wb_datamask, 32'h0000_00FF);

      mem_op(32'h102, 32'd0, 1, 0, 2'b01, 2'b10, 0, 32'h1122_3344, sc, rc);
      chk("hl_data", bus.wb_datafrommem, 32'h0000_1122);
      chk("hl_mask", bus.wb_datamask, 32'h0000_FFFF);

      mem_op(32'h202, 32'h1234_ABCD, 0, 1, 2'b01, 2'b01, 2, 32'd0, sc, rc);
      chk("hs_be", last_be, 4'b1100);
      chk("hs_wdata", last_wdata, 32'hABCD_ABCD);
      chk("hs_we", last_we, 1'b1);
      chk("hs_ctl", bus.wb_ctl, 2'b01);
      chk("hs_nop", bus.wb_nop, 1'b0);

      mem_op(32'h201, 32'h5566_7788, 0, 1, 2'b00, 2'b00, 0, 32'd0, sc, rc);
      chk("bs_be", last_be, 4'b0010);
      chk("bs_wdata", last_wdata, 32'h8888_8888);

      mem_op(32'h400, 32'h0BAD_F00D, 0, 1, 2'b11, 2'b00, 1, 32'd0, sc, rc);
      chk("ws_be", last_be, 4'b1111);
      chk("ws_wdata", last_wdata, 32'h0BAD_F00D);

      mem_op(32'h101, 32'd0, 1, 0, 2'b10, 2'b10, 0, 32'd0, sc, rc);
      chk("mis_stall", sc, 0);
      chk("mis_req", rc, 0);
      chk("mis_pulse", bus.misalign, 1'b1);
      chk("mis_nop", bus.wb_nop, 1'b1);

      mem_op(32'h203, 32'h1, 0, 1, 2'b01, 2'b00, 0, 32'd0, sc, rc);
      chk("mis_hs_pulse", bus.misalign, 1'b1);

      mem_op(32'h300, 32'd0, 1, 0, 2'b10, 2'b10, -1, 32'd0, sc, rc);
      chk("to_req_cycles", rc, 4);
      chk("to_bus_err", bus.bus_err, 1'b1);
      chk("to_req_low", bus.dmem_req, 1'b0);
      chk("to_nop", bus.wb_nop, 1'b1);
      alu_op(32'h0000_CAFE, 2'b10);

      @(posedge clk); #1;
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_0000;
      @(posedge clk); #1;
      bus.dmem_ack = 1'b0;
      chk("idle_ack_req", bus.dmem_req, 1'b0);
      chk("idle_ack_nop", bus.wb_nop, 1'b1);

      @(posedge clk); #1;
      drive(1'b1, 32'h500, 32'd0, 1'b1, 1'b0, 2'b10, 2'b10);
      repeat (2) @(posedge clk);
      #1;
      chk("rw_req_before", bus.dmem_req, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("rw_req_reset", bus.dmem_req, 1'b0);
      chk("rw_stall_reset", bus.stall, 1'b0);
      chk("rw_nop_reset", bus.wb_nop, 1'b1);
      @(posedge clk); #1;
      idle();
      #1 reset = 1'b0;
      @(posedge clk); #1;
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1357_9BDF;
      @(posedge clk); #1;
      bus.dmem_ack = 1'b0;
      chk("late_ack_req", bus.dmem_req, 1'b0);
      chk("late_ack_nop", bus.wb_nop, 1'b1);
      chk("late_ack_data", bus.wb_datafrommem, 32'd0);
      repeat (3) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
